// File: rtl/cordic_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cordic_pkg
// Brief    : Shared constants and helpers for the CORDIC arbiter slice.
// Revision : 1.0 - initial release
// ============================================================================
package cordic_pkg;

    typedef enum logic {
        FUNC_COS = 1'b0,
        FUNC_SIN = 1'b1
    } cordic_func_e;

    localparam int CORDIC_W_DEF       = 12;
    localparam int CORDIC_LATENCY_DEF = 13;

    // Round-robin successor of idx in a ring of n entries.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cordic_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : cordic_arbiter_if
// Brief    : Requester and CORDIC-unit bus bundle for cordic_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface cordic_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int W     = 12
);
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ-1:0]       req_func;
    logic [N_REQ*2*W-1:0]   req_a;
    logic [N_REQ-1:0]       rsp_valid;
    logic [N_REQ-1:0]       rsp_ready;
    logic [N_REQ*W-1:0]     rsp_data;
    logic                   cordic_start;
    logic                   cordic_func;
    logic [2*W-1:0]         cordic_a;
    logic [2*W-1:0]         cordic_b;
    logic                   cordic_valid;
    logic [W-1:0]           cordic_f;

    // Arbiter side
    modport slave (
        input  req_valid, req_func, req_a, rsp_ready, cordic_valid, cordic_f,
        output req_ready, rsp_valid, rsp_data, cordic_start, cordic_func,
               cordic_a, cordic_b
    );

    // Requester / CORDIC-unit side
    modport master (
        output req_valid, req_func, req_a, rsp_ready, cordic_valid, cordic_f,
        input  req_ready, rsp_valid, rsp_data, cordic_start, cordic_func,
               cordic_a, cordic_b
    );
endinterface
`default_nettype wire

// File: rtl/cordic_tag_pipe.sv
`default_nettype none
// ============================================================================
// Module   : cordic_tag_pipe
// Brief    : Fixed-depth tag shift register tracking in-flight CORDIC ops.
// Revision : 1.0 - initial release
// ============================================================================
module cordic_tag_pipe #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 13
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic [WIDTH-1:0] i_tag,
    output logic      [WIDTH-1:0] o_tag
);

    logic [DEPTH-1:0][WIDTH-1:0] r_stage;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stage <= '0;
        end else begin
            r_stage[0] <= i_tag;
            for (int s = 1; s < DEPTH; s++) begin
                r_stage[s] <= r_stage[s-1];
            end
        end
    end

    assign o_tag = r_stage[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/cordic_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cordic_arbiter
// Brief    : Round-robin sharing of one pipelined CORDIC unit between N_REQ
//            requesters with per-requester one-deep response slots.
//            Optional protocol checker enabled by CORDIC_ARB_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module cordic_arbiter
    import cordic_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int W       = CORDIC_W_DEF,
    parameter int LATENCY = CORDIC_LATENCY_DEF
) (
    input  wire logic       clk,
    input  wire logic       rst,
    cordic_arbiter_if.slave bus,
    output logic            busy
`ifdef CORDIC_ARB_CHECK_EN
    ,
    output logic            err
`endif
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int TAG_W = IDX_W + 1;
    localparam int OP_W  = 2 * W;

    logic [N_REQ-1:0]            r_outstanding;
    logic [N_REQ-1:0]            w_eligible;
    logic [N_REQ-1:0]            w_grant;
    logic [N_REQ-1:0]            w_rsp_fire;
    logic [N_REQ-1:0]            r_rsp_valid;
    logic [N_REQ-1:0][W-1:0]     r_rsp_data;
    logic [N_REQ-1:0][OP_W-1:0]  w_req_a;
    logic [IDX_W-1:0]            r_rr_ptr;
    logic [IDX_W-1:0]            w_gnt_idx;
    logic [IDX_W-1:0]            w_cand;
    logic [IDX_W-1:0]            r_issue_id;
    logic                        w_found;
    logic                        r_start;
    cordic_func_e                r_func;
    logic [OP_W-1:0]             r_a;
    logic [TAG_W-1:0]            w_tag_in;
    logic [TAG_W-1:0]            w_tag_out;
    logic                        w_ret_valid;
    logic [IDX_W-1:0]            w_ret_id;

    assign w_req_a    = bus.req_a;
    assign w_eligible = bus.req_valid & ~r_outstanding;
    assign w_rsp_fire = r_rsp_valid & bus.rsp_ready;

    // First eligible index scanning upward from the pointer, with wrap.
    always_comb begin
        w_grant   = '0;
        w_gnt_idx = '0;
        w_found   = 1'b0;
        w_cand    = '0;
        for (int off = 0; off < N_REQ; off++) begin
            w_cand = IDX_W'((int'(r_rr_ptr) + off) % N_REQ);
            if (!w_found && w_eligible[w_cand]) begin
                w_found          = 1'b1;
                w_grant[w_cand]  = 1'b1;
                w_gnt_idx        = w_cand;
            end
        end
    end

    // Issue register: operand and function hold between issues.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_start    <= 1'b0;
            r_func     <= FUNC_COS;
            r_a        <= '0;
            r_issue_id <= '0;
            r_rr_ptr   <= '0;
        end else begin
            r_start <= w_found;
            if (w_found) begin
                r_func     <= cordic_func_e'(bus.req_func[w_gnt_idx]);
                r_a        <= w_req_a[w_gnt_idx];
                r_issue_id <= w_gnt_idx;
                r_rr_ptr   <= IDX_W'(rr_next(int'(w_gnt_idx), N_REQ));
            end
        end
    end

    assign w_tag_in = {r_start, r_issue_id};

    cordic_tag_pipe #(
        .WIDTH (TAG_W),
        .DEPTH (LATENCY)
    ) u_tag_pipe (
        .clk   (clk),
        .rst   (rst),
        .i_tag (w_tag_in),
        .o_tag (w_tag_out)
    );

    assign {w_ret_valid, w_ret_id} = w_tag_out;

    // One op in flight per requester, so a returning result always finds
    // its slot empty and never coincides with that requester's own accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_outstanding <= '0;
            r_rsp_valid   <= '0;
            r_rsp_data    <= '0;
        end else begin
            r_outstanding <= (r_outstanding & ~w_rsp_fire) | w_grant;
            for (int i = 0; i < N_REQ; i++) begin
                if (w_ret_valid && (w_ret_id == IDX_W'(i))) begin
                    r_rsp_valid[i] <= 1'b1;
                    r_rsp_data[i]  <= bus.cordic_f;
                end else if (w_rsp_fire[i]) begin
                    r_rsp_valid[i] <= 1'b0;
                end
            end
        end
    end

    assign bus.req_ready    = rst ? '0 : w_grant;
    assign bus.rsp_valid    = r_rsp_valid;
    assign bus.rsp_data     = r_rsp_data;
    assign bus.cordic_start = r_start;
    assign bus.cordic_func  = r_func;
    assign bus.cordic_a     = r_a;
    assign bus.cordic_b     = '0;
    assign busy             = |r_outstanding;

`ifdef CORDIC_ARB_CHECK_EN
    localparam int MASK_W = $clog2(LATENCY + 1);

    logic [MASK_W-1:0] r_mask_cnt;
    logic              r_err;

    // Results issued before a reset may still drain for LATENCY cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mask_cnt <= '0;
            r_err      <= 1'b0;
        end else if (r_mask_cnt != MASK_W'(LATENCY)) begin
            r_mask_cnt <= r_mask_cnt + MASK_W'(1);
        end else if (bus.cordic_valid != w_ret_valid) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    logic w_unused_cordic_valid;
    assign w_unused_cordic_valid = bus.cordic_valid;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cordic_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cordic_arbiter
// Brief    : Directed self-checking bench for cordic_arbiter with a
//            LATENCY=13 CORDIC stub returning f = a[11:0] ^ func.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cordic_arbiter;

    localparam int NR  = 4;
    localparam int WD  = 12;
    localparam int LAT = 13;

    logic clk = 1'b0;
    logic rst;
    logic busy;
`ifdef CORDIC_ARB_CHECK_EN
    logic err;
`endif

    always #5 clk = ~clk;

    cordic_arbiter_if #(.N_REQ(NR), .W(WD)) bus ();

    cordic_arbiter #(
        .N_REQ   (NR),
        .W       (WD),
        .LATENCY (LAT)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
`ifdef CORDIC_ARB_CHECK_EN
        ,
        .err  (err)
`endif
    );

    // CORDIC stub: not reset by rst, so pre-reset results still emerge.
    logic          stub_clr;
    logic          spur;
    logic [LAT-1:0] stub_v;
    logic [WD-1:0] stub_f [LAT];

    always @(posedge clk) begin
        if (stub_clr) begin
            stub_v <= '0;
            for (int s = 0; s < LAT; s++) stub_f[s] <= '0;
        end else begin
            stub_v    <= {stub_v[LAT-2:0], bus.cordic_start | spur};
            stub_f[0] <= bus.cordic_a[WD-1:0] ^ {{(WD-1){1'b0}}, bus.cordic_func};
            for (int s = 1; s < LAT; s++) stub_f[s] <= stub_f[s-1];
        end
    end

    assign bus.cordic_valid = stub_v[LAT-1];
    assign bus.cordic_f     = stub_f[LAT-1];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic to_neg();
        @(negedge clk);
    endtask

    task automatic to_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.rsp_ready = '0;
        to_neg(); to_drive(); to_neg(); to_drive();
        rst = 1'b0;
    endtask

    task automatic drain(input int cycles);
        bus.req_valid = '0;
        bus.rsp_ready = '1;
        for (int c = 0; c < cycles; c++) begin to_neg(); to_drive(); end
        bus.rsp_ready = '0;
    endtask

    typedef struct {
        int          id;
        logic        func;
        logic [23:0] a;
        logic [11:0] exp;
    } vec_t;

    vec_t vecs [5];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  oh;
        logic [47:0] m;
        logic [3:0]  seen;
        logic [3:0]  g;
        logic        bad;
        logic        stale_seen;
        int          id;
        int          ng;
        int          tv;
        logic [23:0] t2_a   [4];
        logic [11:0] t2_exp [4];

        vecs[0] = '{id: 2, func: 1'b1, a: 24'h000123, exp: 12'h122};
        vecs[1] = '{id: 0, func: 1'b0, a: 24'hABCFFF, exp: 12'hFFF};
        vecs[2] = '{id: 1, func: 1'b1, a: 24'h000800, exp: 12'h801};
        vecs[3] = '{id: 3, func: 1'b0, a: 24'h123456, exp: 12'h456};
        vecs[4] = '{id: 3, func: 1'b1, a: 24'hFFFFFF, exp: 12'hFFE};
        t2_a[0] = 24'h000010; t2_exp[0] = 12'h010;
        t2_a[1] = 24'h555321; t2_exp[1] = 12'h320;
        t2_a[2] = 24'h000ABC; t2_exp[2] = 12'hABC;
        t2_a[3] = 24'hFFF00F; t2_exp[3] = 12'h00E;

        stub_clr      = 1'b1;
        spur          = 1'b0;
        bus.req_func  = '0;
        bus.req_a     = '0;
        do_reset();
        stub_clr = 1'b0;

        // Reset state
        to_neg();
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_data", bus.rsp_data, 0);
        chk("rst_cordic_start", bus.cordic_start, 0);
        chk("rst_cordic_a", bus.cordic_a, 0);
        chk("rst_cordic_b", bus.cordic_b, 0);
        chk("rst_busy", busy, 0);
`ifdef CORDIC_ARB_CHECK_EN
        chk("rst_err", err, 0);
`endif
        to_drive();

        // Single requests, table driven
        foreach (vecs[v]) begin
            id            = vecs[v].id;
            oh            = 4'b0001 << id;
            bus.req_valid = oh;
            bus.req_func  = '0;
            bus.req_func[id] = vecs[v].func;
            bus.req_a     = '0;
            bus.req_a[24*id +: 24] = vecs[v].a;
            to_neg();
            chk("t1_grant", bus.req_ready, oh);
            to_drive();
            bus.req_valid = '0;
            for (int n = 1; n <= 15; n++) begin
                to_neg();
                if (n == 1) begin
                    chk("t1_start", bus.cordic_start, 1);
                    chk("t1_func", bus.cordic_func, vecs[v].func);
                    chk("t1_operand", bus.cordic_a, vecs[v].a);
                end
                if (n == 2) chk("t1_start_pulse", bus.cordic_start, 0);
                if (n == 14) chk("t1_rsp_early", bus.rsp_valid, 0);
                if (n == 15) begin
                    chk("t1_rsp_valid", bus.rsp_valid, oh);
                    chk("t1_rsp_data", bus.rsp_data[12*id +: 12], vecs[v].exp);
                    chk("t1_busy", busy, 1);
                    if (v == 0) begin
                        m = ~(48'hFFF << (12*id));
                        chk("t1_other_data", bus.rsp_data & m, 0);
                    end
                end
                to_drive();
            end
            bus.rsp_ready = oh;
            to_neg(); to_drive();
            bus.rsp_ready = '0;
            to_neg();
            chk("t1_rsp_clear", bus.rsp_valid, 0);
            chk("t1_idle", busy, 0);
            to_drive();
        end

        // All four requesters at once
        do_reset();
        bus.req_func  = 4'b1010;
        bus.req_a     = {t2_a[3], t2_a[2], t2_a[1], t2_a[0]};
        bus.req_valid = 4'hF;
        for (int c = 0; c < 4; c++) begin
            to_neg();
            chk("t2_grant", bus.req_ready, 4'b0001 << c);
            to_drive();
            bus.req_valid[c] = 1'b0;
        end
        seen = '0;
        for (int t = 4; t <= 24; t++) begin
            to_neg();
            for (int i = 0; i < 4; i++) begin
                if (bus.rsp_valid[i] && !seen[i]) begin
                    seen[i] = 1'b1;
                    chk("t2_rsp_time", t, i + 15);
                    chk("t2_rsp_data", bus.rsp_data[12*i +: 12], t2_exp[i]);
                end
            end
            to_drive();
        end
        chk("t2_all_rsp", seen, 4'hF);
        drain(2);

        // Round-robin fairness between requesters 0 and 1
        do_reset();
        bus.req_valid = 4'b0011;
        bus.rsp_ready = 4'hF;
        ng = 0;
        for (int t = 0; t < 60; t++) begin
            to_neg();
            g = bus.req_ready & bus.req_valid;
            if (g != 0) begin
                chk("t3_onehot", $countones(g), 1);
                chk("t3_grant_id", g[1] ? 1 : 0, ng % 2);
                chk("t3_grant_time", t, (ng / 2) * 16 + (ng % 2));
                ng++;
            end
            to_drive();
        end
        chk("t3_grant_count", ng, 8);
        drain(20);

        // Response back-pressure on requester 1
        do_reset();
        bus.req_valid = 4'b0010;
        to_neg();
        chk("t4_grant", bus.req_ready, 4'b0010);
        to_drive();
        bad = 1'b0;
        for (int t = 1; t <= 30; t++) begin
            to_neg();
            if (bus.req_ready[1]) bad = 1'b1;
            if (t == 30) chk("t4_rsp_held", bus.rsp_valid[1], 1);
            to_drive();
        end
        chk("t4_blocked", bad, 0);
        bus.rsp_ready = 4'b0010;
        to_neg();
        chk("t4_no_grant_on_accept", bus.req_ready[1], 0);
        to_drive();
        bus.rsp_ready = '0;
        to_neg();
        chk("t4_regrant", bus.req_ready[1], 1);
        to_drive();
        drain(20);

        // Reset in the middle of an operation
        do_reset();
        bus.req_func  = 4'b0001;
        bus.req_a     = '0;
        bus.req_a[23:0] = 24'h00ABCD;
        bus.req_valid = 4'b0001;
        to_neg();
        chk("t5_grant", bus.req_ready, 4'b0001);
        to_drive();
        bus.req_valid = '0;
        for (int n = 1; n <= 5; n++) begin to_neg(); to_drive(); end
        rst = 1'b1;
        to_neg(); to_drive();
        rst = 1'b0;
        to_neg();
        chk("t5_rsp_valid", bus.rsp_valid, 0);
        chk("t5_rsp_data", bus.rsp_data, 0);
        chk("t5_start", bus.cordic_start, 0);
        chk("t5_func", bus.cordic_func, 0);
        chk("t5_operand", bus.cordic_a, 0);
        chk("t5_busy", busy, 0);
        to_drive();
        bad = 1'b0;
        stale_seen = 1'b0;
        for (int t = 0; t < 20; t++) begin
            to_neg();
            if (bus.cordic_valid) stale_seen = 1'b1;
            if (bus.rsp_valid != 0) bad = 1'b1;
`ifdef CORDIC_ARB_CHECK_EN
            if (err) bad = 1'b1;
`endif
            to_drive();
        end
        chk("t5_stale_emitted", stale_seen, 1);
        chk("t5_no_stale_effect", bad, 0);

        // Spurious CORDIC valid with no issue outstanding
        spur = 1'b1;
        to_neg(); to_drive();
        spur = 1'b0;
        tv  = -1;
        bad = 1'b0;
        for (int t = 1; t <= 20; t++) begin
            to_neg();
            if (bus.rsp_valid != 0) bad = 1'b1;
`ifdef CORDIC_ARB_CHECK_EN
            if (tv >= 0 && t == tv + 1) chk("t6_err_set", err, 1);
            if (tv >= 0 && t > tv + 1 && !err) bad = 1'b1;
            if (bus.cordic_valid && tv < 0) begin
                tv = t;
                chk("t6_err_before", err, 0);
            end
`else
            if (bus.cordic_valid && tv < 0) tv = t;
`endif
            to_drive();
        end
        chk("t6_spur_seen", tv, 13);
        chk("t6_no_rsp_sticky", bad, 0);
`ifdef CORDIC_ARB_CHECK_EN
        do_reset();
        to_neg();
        chk("t6_err_cleared", err, 0);
        to_drive();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
